// File: rtl/pwm_bank.sv
//------------------------------------------------------------------------------
// Module   : pwm_bank
// Purpose  : Bank of NCH PWM channels behind a simple cs/addr/rd/wr register
//            bus. Each channel has EN, PERIOD and DUTY registers. PERIOD and
//            DUTY are written to pending copies that the engine picks up only
//            at period boundaries (or continuously while idle / period 0), so
//            the outputs never glitch mid-period.
// Ports    : clk    - system clock
//            rst_n  - asynchronous active-low reset
//            cs     - chip select
//            addr   - byte address (channel c base = c*12; +0 EN, +4 PERIOD,
//                     +8 DUTY)
//            rd     - read strobe, d_out loaded one cycle later
//            wr     - write strobe
//            d_in   - write data
//            d_out  - registered read data (holds when not reading)
//            pwm    - registered PWM outputs, one per channel
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pwm_bank #(
  parameter int NCH = 8,
  parameter int W   = 16,
  parameter int AW  = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cs,
  input  logic [AW-1:0]  addr,
  input  logic           rd,
  input  logic           wr,
  input  logic [W-1:0]   d_in,
  output logic [W-1:0]   d_out,
  output logic [NCH-1:0] pwm
);

  logic [NCH-1:0] en_q;
  logic [W-1:0]   per_pend  [NCH];
  logic [W-1:0]   duty_pend [NCH];
  logic [W-1:0]   per_act   [NCH];
  logic [W-1:0]   duty_act  [NCH];
  logic [W-1:0]   cnt       [NCH];

  logic           wr_en;
  logic           rd_en;
  logic [NCH-1:0] hit_en;
  logic [NCH-1:0] hit_per;
  logic [NCH-1:0] hit_duty;
  logic [W-1:0]   per_nxt   [NCH];
  logic [W-1:0]   duty_nxt  [NCH];
  logic [W-1:0]   rdata;

  assign wr_en = cs && wr;
  assign rd_en = cs && rd;

  // Address decode: only exact register addresses match, so unaligned and
  // out-of-range addresses fall through with no hit (writes ignored, reads 0).
  always_comb begin
    hit_en   = '0;
    hit_per  = '0;
    hit_duty = '0;
    for (int c = 0; c < NCH; c++) begin
      hit_en[c]   = (addr == AW'(c * 12));
      hit_per[c]  = (addr == AW'(c * 12 + 4));
      hit_duty[c] = (addr == AW'(c * 12 + 8));
    end
  end

  // Next pending values. The engine loads active values from these rather
  // than from the pending registers so a write landing on the same edge as a
  // wrap is captured by that wrap.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      per_nxt[c]  = (wr_en && hit_per[c])  ? d_in : per_pend[c];
      duty_nxt[c] = (wr_en && hit_duty[c]) ? d_in : duty_pend[c];
    end
  end

  // Read mux returns pending values; sampled before any same-edge write.
  always_comb begin
    rdata = '0;
    for (int c = 0; c < NCH; c++) begin
      if (hit_en[c])   rdata = {{(W-1){1'b0}}, en_q[c]};
      if (hit_per[c])  rdata = per_pend[c];
      if (hit_duty[c]) rdata = duty_pend[c];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q  <= '0;
      d_out <= '0;
      pwm   <= '0;
      for (int c = 0; c < NCH; c++) begin
        per_pend[c]  <= '0;
        duty_pend[c] <= '0;
        per_act[c]   <= '0;
        duty_act[c]  <= '0;
        cnt[c]       <= '0;
      end
    end else begin
      if (rd_en) begin
        d_out <= rdata;
      end
      for (int c = 0; c < NCH; c++) begin
        if (wr_en && hit_en[c]) begin
          en_q[c] <= d_in[0];
        end
        per_pend[c]  <= per_nxt[c];
        duty_pend[c] <= duty_nxt[c];

        if (!en_q[c] || (per_act[c] == '0)) begin
          // Idle or zero period: output low, counter parked, active values
          // follow pending so the first period after enable uses fresh values.
          cnt[c]      <= '0;
          pwm[c]      <= 1'b0;
          per_act[c]  <= per_nxt[c];
          duty_act[c] <= duty_nxt[c];
        end else begin
          pwm[c] <= (cnt[c] < duty_act[c]);
          if (cnt[c] == per_act[c] - W'(1)) begin
            cnt[c]      <= '0;
            per_act[c]  <= per_nxt[c];
            duty_act[c] <= duty_nxt[c];
          end else begin
            cnt[c] <= cnt[c] + W'(1);
          end
        end
      end
    end
  end

endmodule

`default_nettype wire
